// File: rtl/aidan_mcnay_prime_div_ctrl_pkg.sv
// Shared definitions for the trial-division primality controller.
// Optional macro AIDAN_MCNAY_PRIME_ODD_SKIP_EN selects the 2-then-odd divisor sequence.
package aidan_mcnay_prime_div_ctrl_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int unsigned D_INIT = 2;

endpackage

// File: rtl/aidan_mcnay_prime_trial_eval.sv
// Combinational evaluation of one trial quotient q = floor(n/d).
// Stops with prime when q < d, stops with composite when d divides n exactly.
module aidan_mcnay_prime_trial_eval
    import aidan_mcnay_prime_div_ctrl_pkg::*;
#(
    parameter int nbits = 16
) (
    input  logic [nbits-1:0] n_i,
    input  logic [nbits-1:0] d_i,
    input  logic [nbits-1:0] q_i,
    output logic             done_o,
    output logic             is_prime_o
);

    logic [nbits-1:0] prod;

    // q*d never exceeds n, so the truncated product is exact.
    always_comb begin
        prod       = q_i * d_i;
        is_prime_o = (q_i < d_i);
        done_o     = is_prime_o || (prod == n_i);
    end

endmodule

// File: rtl/aidan_mcnay_prime_div_ctrl.sv
// Trial-division primality controller driving one external val/rdy divider.
// Define AIDAN_MCNAY_PRIME_ODD_SKIP_EN to try only 2 and odd divisors.
//
// state | meaning
// IDLE  | waiting for a candidate
// ISSUE | presenting n / d to the divider
// WAIT  | request accepted, waiting for the quotient
// DONE  | verdict presented on ostream
module aidan_mcnay_prime_div_ctrl
    import aidan_mcnay_prime_div_ctrl_pkg::*;
#(
    parameter int nbits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] istream_msg,
    input  logic             istream_val,
    output logic             istream_rdy,
    output logic             ostream_msg,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] div_opa,
    output logic [nbits-1:0] div_opb,
    output logic             div_istream_val,
    input  logic             div_istream_rdy,
    input  logic [nbits-1:0] div_result,
    input  logic             div_ostream_val,
    output logic             div_ostream_rdy
);

    logic [1:0]       state_q, state_d;
    logic [nbits-1:0] n_q, n_d;
    logic [nbits-1:0] d_q, d_d;
    logic             verdict_q, verdict_d;
    logic [nbits-1:0] d_next;
    logic             eval_en;
    logic             eval_done;
    logic             eval_prime;

    aidan_mcnay_prime_trial_eval #(.nbits(nbits)) u_eval (
        .n_i        (n_q),
        .d_i        (d_q),
        .q_i        (div_result),
        .done_o     (eval_done),
        .is_prime_o (eval_prime)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            n_q       <= '0;
            d_q       <= '0;
            verdict_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            d_q       <= d_d;
            verdict_q <= verdict_d;
        end
    end

    always_comb begin
`ifdef AIDAN_MCNAY_PRIME_ODD_SKIP_EN
        d_next = (d_q == nbits'(D_INIT)) ? d_q + nbits'(1) : d_q + nbits'(2);
`else
        d_next = d_q + nbits'(1);
`endif
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        d_d       = d_q;
        verdict_d = verdict_q;
        eval_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (istream_val) begin
                    n_d = istream_msg;
                    if (istream_msg < nbits'(2)) begin
                        verdict_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        d_d     = nbits'(D_INIT);
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // A zero-latency divider answers in the same cycle it accepts.
                if (div_istream_rdy) begin
                    if (div_ostream_val) begin
                        eval_en = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (div_ostream_val) begin
                    eval_en = 1'b1;
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (eval_en) begin
            if (eval_done) begin
                verdict_d = eval_prime;
                state_d   = DONE;
            end else begin
                d_d     = d_next;
                state_d = ISSUE;
            end
        end
    end

    always_comb begin
        istream_rdy     = (state_q == IDLE);
        div_istream_val = (state_q == ISSUE);
        div_ostream_rdy = (state_q == ISSUE) || (state_q == WAIT);
        ostream_val     = (state_q == DONE);
        ostream_msg     = (state_q == DONE) && verdict_q;
        div_opa         = n_q;
        div_opb         = d_q;
    end

endmodule

// File: tb/tb_aidan_mcnay_prime_div_ctrl.sv
// Self-checking bench for the primality controller with a configurable divider responder.
module tb_aidan_mcnay_prime_div_ctrl;
    import aidan_mcnay_prime_div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] istream_msg;
    logic        istream_val;
    logic        istream_rdy;
    logic        ostream_msg;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [15:0] div_opa;
    logic [15:0] div_opb;
    logic        div_istream_val;
    logic        div_istream_rdy;
    logic [15:0] div_result;
    logic        div_ostream_val;
    logic        div_ostream_rdy;

    int n_vec  = 0;
    int n_miss = 0;

    aidan_mcnay_prime_div_ctrl #(.nbits(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .istream_msg     (istream_msg),
        .istream_val     (istream_val),
        .istream_rdy     (istream_rdy),
        .ostream_msg     (ostream_msg),
        .ostream_val     (ostream_val),
        .ostream_rdy     (ostream_rdy),
        .div_opa         (div_opa),
        .div_opb         (div_opb),
        .div_istream_val (div_istream_val),
        .div_istream_rdy (div_istream_rdy),
        .div_result      (div_result),
        .div_ostream_val (div_ostream_val),
        .div_ostream_rdy (div_ostream_rdy)
    );

    always #5 clk = ~clk;

    // ---------------- divider responder ----------------
    int          req_stall = 0;
    int          resp_lat  = 0;
    int          stall_left = 0;
    int          lat_left   = 0;
    logic        busy = 1'b0;
    logic [15:0] held_q = '0;
    logic        comb_mode;

    function automatic logic [15:0] safe_div(input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) ? 16'd0 : a / b;
    endfunction

    always_comb begin
        comb_mode = (req_stall == 0) && (resp_lat == 0);
        if (comb_mode) begin
            div_istream_rdy = 1'b1;
            div_ostream_val = div_istream_val;
            div_result      = safe_div(div_opa, div_opb);
        end else begin
            div_istream_rdy = !busy && (stall_left == 0);
            div_ostream_val = busy && (lat_left == 0);
            div_result      = busy ? held_q : 16'd0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            stall_left <= req_stall;
            lat_left   <= 0;
        end else if (busy) begin
            if (lat_left > 0) lat_left <= lat_left - 1;
            else if (div_ostream_rdy) begin
                busy       <= 1'b0;
                stall_left <= req_stall;
            end
        end else if (div_istream_val && !comb_mode) begin
            if (stall_left > 0) stall_left <= stall_left - 1;
            else begin
                busy     <= 1'b1;
                held_q   <= safe_div(div_opa, div_opb);
                lat_left <= resp_lat;
            end
        end else if (!div_istream_val) begin
            stall_left <= req_stall;
        end
    end

    // ---------------- monitors ----------------
    int          fires = 0, val_cycles = 0, stall_cycles = 0, stab_err = 0;
    logic [15:0] last_d = '0, last_q = '0, prev_opa = '0, prev_opb = '0;
    logic        prev_pend = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            if (div_istream_val && div_istream_rdy) fires <= fires + 1;
            if (div_istream_val) val_cycles <= val_cycles + 1;
            if (div_istream_val && !div_istream_rdy) stall_cycles <= stall_cycles + 1;
            if (div_ostream_val && div_ostream_rdy) begin
                last_d <= div_opb;
                last_q <= div_result;
            end
            if (prev_pend && ((div_opa != prev_opa) || (div_opb != prev_opb))) stab_err <= stab_err + 1;
        end
        prev_pend <= !reset && div_istream_val && !div_istream_rdy;
        prev_opa  <= div_opa;
        prev_opb  <= div_opb;
    end

    // ---------------- reference model ----------------
    function automatic int ref_prime(input int n);
        if (n < 2) return 0;
        for (int i = 2; i * i <= n; i++) if (n % i == 0) return 0;
        return 1;
    endfunction

    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Last divisor tried: smallest factor if composite, else first sequence member above sqrt(n).
    function automatic int ref_stop(input int n);
        int s;
        for (int i = 2; i * i <= n; i++) if (n % i == 0) return i;
        s = isqrt(n) + 1;
`ifdef AIDAN_MCNAY_PRIME_ODD_SKIP_EN
        if (s > 2 && (s % 2) == 0) s++;
`endif
        return s;
    endfunction

    function automatic int seq_count(input int x);
`ifdef AIDAN_MCNAY_PRIME_ODD_SKIP_EN
        return (x == 2) ? 1 : 1 + (x - 1) / 2;
`else
        return x - 1;
`endif
    endfunction

    function automatic int ref_trials(input int n);
        return (n < 2) ? 0 : seq_count(ref_stop(n));
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: timed out", name);
    endtask

    // Returns at the negedge where ostream_val is first seen.
    task automatic run_cand(input int n, output int verdict, output int cycles,
                            output int trials, output int vals);
        int f0, v0, guard;
        @(negedge clk);
        istream_msg = n[15:0];
        istream_val = 1'b1;
        guard = 0;
        while (!istream_rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!istream_rdy) timeout("accept");
        f0 = fires;
        v0 = val_cycles;
        @(posedge clk);
        @(negedge clk);
        istream_val = 1'b0;
        cycles = 1;
        while (!ostream_val && cycles < 4000) begin
            @(negedge clk);
            cycles++;
        end
        if (!ostream_val) timeout("verdict");
        verdict = int'(ostream_msg);
        trials  = fires - f0;
        vals    = val_cycles - v0;
    endtask

    task automatic finish_out(input string name);
        ostream_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(name, int'({istream_rdy, ostream_val}), 2);
    endtask

    typedef struct {
        int n;
        int exp_prime;
        int exp_trials_plain;
        int exp_trials_odd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int v, cyc, tr, vals, exp_tr, mode, n;
        string nm;

        vecs[0] = '{0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 0};
        vecs[2] = '{2, 1, 1, 1};
        vecs[3] = '{3, 1, 1, 1};
        vecs[4] = '{4, 0, 1, 1};
        vecs[5] = '{9, 0, 2, 2};
        vecs[6] = '{25, 0, 4, 3};
        vecs[7] = '{91, 0, 6, 4};
        vecs[8] = '{97, 1, 9, 6};
        vecs[9] = '{65521, 1, 255, 129};

        reset       = 1'b1;
        istream_msg = '0;
        istream_val = 1'b0;
        ostream_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            int'({istream_rdy, ostream_val, ostream_msg, div_istream_val, div_ostream_rdy}), 16);
        chk("reset_operands", int'({div_opa, div_opb}), 0);
        chk("reset_state", int'(dut.state_q), int'(IDLE));
        reset = 1'b0;

        // Directed table with a zero-latency divider.
        for (int i = 0; i < 10; i++) begin
`ifdef AIDAN_MCNAY_PRIME_ODD_SKIP_EN
            exp_tr = vecs[i].exp_trials_odd;
`else
            exp_tr = vecs[i].exp_trials_plain;
`endif
            run_cand(vecs[i].n, v, cyc, tr, vals);
            nm = $sformatf("n=%0d", vecs[i].n);
            chk({nm, " verdict"}, v, vecs[i].exp_prime);
            chk({nm, " trials"}, tr, exp_tr);
            chk({nm, " latency"}, cyc, 1 + exp_tr);
            if (vecs[i].n < 2) chk({nm, " div_val_cycles"}, vals, 0);
            if (vecs[i].n == 65521) begin
                chk("65521 last_d", int'(last_d), ref_stop(65521));
                chk("65521 last_q", int'(last_q), 65521 / ref_stop(65521));
            end
            finish_out({nm, " handoff"});
        end

        // Output backpressure: verdict held, no new candidate accepted.
        ostream_rdy = 1'b0;
        run_cand(91, v, cyc, tr, vals);
        chk("bp verdict", v, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold %0d", i), int'({ostream_val, ostream_msg, istream_rdy}), 4);
        end
        finish_out("bp handoff");

        // Stalled divider: request refused 3 cycles, response delayed 2 cycles.
        req_stall = 3;
        resp_lat  = 2;
        run_cand(91, v, cyc, tr, vals);
        chk("stall verdict", v, 0);
        chk("stall trials", tr, ref_trials(91));
        chk("stall operand stability", stab_err, 0);
        chk("stall observed", int'(stall_cycles >= 3 * ref_trials(91)), 1);
        finish_out("stall handoff");
        req_stall = 0;
        resp_lat  = 0;

        // Reset while in ISSUE.
        @(negedge clk);
        istream_msg = 16'd97;
        istream_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        istream_val = 1'b0;
        chk("pre-reset in ISSUE", int'(div_istream_val), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid reset outputs",
            int'({istream_rdy, ostream_val, div_istream_val, div_ostream_rdy}), 8);
        chk("mid reset state", int'(dut.state_q), int'(IDLE));
        reset = 1'b0;
        run_cand(97, v, cyc, tr, vals);
        chk("post-reset 97 verdict", v, 1);
        finish_out("post-reset handoff");

        // Randomized candidates against the reference model.
        for (int i = 0; i < 60; i++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                req_stall = 0;
                resp_lat  = 0;
                n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535))
                                                : int'($urandom_range(0, 300));
            end else begin
                req_stall = int'($urandom_range(0, 3));
                resp_lat  = int'($urandom_range(0, 3));
                n = int'($urandom_range(0, 1500));
            end
            run_cand(n, v, cyc, tr, vals);
            nm = $sformatf("rand n=%0d", n);
            chk({nm, " verdict"}, v, ref_prime(n));
            chk({nm, " trials"}, tr, ref_trials(n));
            if (req_stall == 0 && resp_lat == 0) chk({nm, " latency"}, cyc, 1 + ref_trials(n));
            finish_out({nm, " handoff"});
        end
        req_stall = 0;
        resp_lat  = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
